// File: rtl/arm_fetch_if.sv
// Fetch-stage signal bundle: instruction-memory request/ack channel,
// instruction valid/ready channel to the core, and redirect/halt control.
// The master modport is the fetch stage; the slave modport is its environment.
interface arm_fetch_if;
    // Instruction memory channel
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    // Core-facing instruction channel
    logic        inst_valid;
    logic [31:0] inst;
    logic [29:0] inst_pc;
    logic        inst_ready;
    // Control from the core
    logic        redirect;
    logic [29:0] redirect_addr;
    logic        halt;
    logic        halted;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc, halted,
        input  imem_ack, imem_rdata, inst_ready, redirect, redirect_addr, halt
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, halted,
        output imem_ack, imem_rdata, inst_ready, redirect, redirect_addr, halt
    );
endinterface

// File: rtl/arm_fetch.sv
// Instruction fetch stage. Owns the word-address fetch PC, issues requests to
// instruction memory, buffers returned words (tagged with their PC) in a small
// FIFO and presents the head to the core. Redirect flushes and restarts fetch
// from a new address; halt stops fetching once any outstanding request lands.
module arm_fetch #(
    parameter int          DEPTH    = 4,
    parameter logic [29:0] RESET_PC = 30'h0
) (
    input  logic         clk,
    input  logic         rst,
    arm_fetch_if.master  bus
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALT_PEND,
        ST_HALTED
    } state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW:0]   count_reg, count_next;
    logic [29:0]   fetch_pc_reg, fetch_pc_next;
    logic          req_reg, req_next;
    logic          halted_reg, halted_next;
    logic          push;
    logic          pop;

    // FIFO storage: instruction word plus the PC it was fetched from
    logic [31:0]   data_mem [DEPTH];
    logic [29:0]   pc_mem   [DEPTH];

    // Next-state logic: redirect overrides everything, otherwise the FIFO
    // bookkeeping and the run/halt sequencing are evaluated together
    always_comb begin
        state_next    = state_reg;
        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;
        count_next    = count_reg;
        fetch_pc_next = fetch_pc_reg;
        req_next      = req_reg;
        push          = 1'b0;
        pop           = (count_reg != '0) && bus.inst_ready;

        if (bus.redirect) begin
            // Data arriving this cycle belongs to the wrong path: drop it
            state_next    = ST_RUN;
            rd_ptr_next   = '0;
            wr_ptr_next   = '0;
            count_next    = '0;
            fetch_pc_next = bus.redirect_addr;
            req_next      = 1'b1;
        end else begin
            push = req_reg && bus.imem_ack;

            if (push) begin
                wr_ptr_next   = wr_ptr_reg + AW'(1);
                fetch_pc_next = fetch_pc_reg + 30'd1;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + AW'(1);
            end
            if (push && !pop) begin
                count_next = count_reg + (AW+1)'(1);
            end else if (pop && !push) begin
                count_next = count_reg - (AW+1)'(1);
            end

            case (state_reg)
                ST_RUN: begin
                    if (bus.halt) begin
                        if (req_reg && !bus.imem_ack) begin
                            // A request is on the bus; it must complete first
                            state_next = ST_HALT_PEND;
                            req_next   = 1'b1;
                        end else begin
                            state_next = ST_HALTED;
                            req_next   = 1'b0;
                        end
                    end else begin
                        req_next = (count_next < FULL);
                    end
                end
                ST_HALT_PEND: begin
                    if (bus.imem_ack) begin
                        state_next = ST_HALTED;
                        req_next   = 1'b0;
                    end else begin
                        req_next = 1'b1;
                    end
                end
                default: begin
                    req_next = 1'b0;
                end
            endcase
        end

        halted_next = (state_next == ST_HALTED);
    end

    // Control and pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_RUN;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            fetch_pc_reg <= RESET_PC;
            req_reg      <= 1'b0;
            halted_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
            count_reg    <= count_next;
            fetch_pc_reg <= fetch_pc_next;
            req_reg      <= req_next;
            halted_reg   <= halted_next;
        end
    end

    // FIFO write port; entries clear on reset so the head reads as zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (push) begin
            data_mem[wr_ptr_reg] <= bus.imem_rdata;
            pc_mem[wr_ptr_reg]   <= fetch_pc_reg;
        end
    end

    // The request address is the fetch PC itself, so it cannot drift from it
    assign bus.imem_req   = req_reg;
    assign bus.imem_addr  = fetch_pc_reg;
    assign bus.inst_valid = (count_reg != '0);
    assign bus.inst       = data_mem[rd_ptr_reg];
    assign bus.inst_pc    = pc_mem[rd_ptr_reg];
    assign bus.halted     = halted_reg;

endmodule

// File: tb/tb_arm_fetch.sv
// Testbench for arm_fetch: directed scenarios plus a randomized run checked
// against a transaction-level model (queue of expected PCs, fetch address,
// run/pending/halted mode). Memory returns a fixed hash of the address.
module tb_arm_fetch;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    arm_fetch_if bus();

    arm_fetch #(.DEPTH(DEPTH), .RESET_PC(30'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [29:0] m_q[$];
    logic [29:0] m_pc;
    logic        m_req;
    logic        m_halted;
    logic        m_pend;

    function automatic logic [31:0] pat(input logic [29:0] a);
        return {a[13:0], a[29:12]} ^ 32'hC0DE_1234;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pc     = 30'h0;
        m_req    = 1'b0;
        m_halted = 1'b0;
        m_pend   = 1'b0;
    endtask

    // Advance the model by one clock given this cycle's inputs
    task automatic model_step(input logic a, input logic r, input logic rd,
                              input logic [29:0] ra, input logic h);
        logic xfer;
        logic popd;
        xfer = m_req && a;
        popd = (m_q.size() != 0) && r;
        if (rd) begin
            m_q.delete();
            m_pc     = ra;
            m_req    = 1'b1;
            m_halted = 1'b0;
            m_pend   = 1'b0;
        end else begin
            if (popd) void'(m_q.pop_front());
            if (xfer) begin
                m_q.push_back(m_pc);
                m_pc = m_pc + 30'd1;
            end
            if (m_pend) begin
                if (a) begin
                    m_pend   = 1'b0;
                    m_halted = 1'b1;
                    m_req    = 1'b0;
                end
            end else if (m_halted) begin
                m_req = 1'b0;
            end else if (h) begin
                if (m_req && !a) m_pend = 1'b1;
                else begin
                    m_halted = 1'b1;
                    m_req    = 1'b0;
                end
            end else begin
                m_req = (m_q.size() < DEPTH);
            end
        end
    endtask

    // Apply inputs at the falling edge, clock once, return at the next falling edge
    task automatic drive(input logic a, input logic r, input logic rd,
                         input logic [29:0] ra, input logic h);
        bus.imem_ack      = a;
        bus.inst_ready    = r;
        bus.redirect      = rd;
        bus.redirect_addr = ra;
        bus.halt          = h;
        bus.imem_rdata    = pat(bus.imem_addr);
        model_step(a, r, rd, ra, h);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.imem_ack = 1'b0; bus.inst_ready = 1'b0; bus.redirect = 1'b0;
        bus.redirect_addr = 30'h0; bus.halt = 1'b0; bus.imem_rdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.imem_ack = 1'b0; bus.inst_ready = 1'b0; bus.redirect = 1'b0;
        bus.redirect_addr = 30'h0; bus.halt = 1'b0; bus.imem_rdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%0b exp=0", bus.imem_req); end
        n_chk++; if (bus.imem_addr !== 30'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", bus.imem_addr); end
        n_chk++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", bus.inst_valid); end
        n_chk++; if (bus.inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst got=%h exp=0", bus.inst); end
        n_chk++; if (bus.inst_pc !== 30'h0) begin n_fail++; $display("FAIL reset_inst_pc got=%h exp=0", bus.inst_pc); end
        n_chk++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got=%0b exp=0", bus.halted); end
        $display("test_reset done");
    endtask

    task automatic test_stream();
        do_reset();
        drive(1, 1, 0, 30'h0, 0);
        n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 30'h0) begin n_fail++; $display("FAIL stream_first_req got req=%0b addr=%h exp req=1 addr=0", bus.imem_req, bus.imem_addr); end
        n_chk++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL stream_valid_c1 got=%0b exp=0", bus.inst_valid); end
        for (int k = 2; k < 9; k++) begin
            drive(1, 1, 0, 30'h0, 0);
            n_chk++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 30'(k-2) || bus.inst !== pat(30'(k-2)))
                begin n_fail++; $display("FAIL stream_head c%0d got v=%0b pc=%h inst=%h exp v=1 pc=%h inst=%h", k, bus.inst_valid, bus.inst_pc, bus.inst, 30'(k-2), pat(30'(k-2))); end
            n_chk++; if (bus.imem_addr !== 30'(k-1)) begin n_fail++; $display("FAIL stream_addr c%0d got=%h exp=%h", k, bus.imem_addr, 30'(k-1)); end
        end
        $display("test_stream done");
    endtask

    task automatic test_full();
        do_reset();
        for (int k = 0; k < 5; k++) drive(1, 0, 0, 30'h0, 0);
        n_chk++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 30'h4) begin n_fail++; $display("FAIL full_req got req=%0b addr=%h exp req=0 addr=4", bus.imem_req, bus.imem_addr); end
        n_chk++; if (bus.inst_pc !== 30'h0) begin n_fail++; $display("FAIL full_head got=%h exp=0", bus.inst_pc); end
        drive(1, 0, 0, 30'h0, 0);
        n_chk++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 30'h4) begin n_fail++; $display("FAIL full_hold got req=%0b addr=%h exp req=0 addr=4", bus.imem_req, bus.imem_addr); end
        drive(1, 1, 0, 30'h0, 0);
        n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 30'h4) begin n_fail++; $display("FAIL full_reenable got req=%0b addr=%h exp req=1 addr=4", bus.imem_req, bus.imem_addr); end
        n_chk++; if (bus.inst_pc !== 30'h1) begin n_fail++; $display("FAIL full_popped got=%h exp=1", bus.inst_pc); end
        $display("test_full done");
    endtask

    task automatic test_ack_stall();
        do_reset();
        drive(0, 0, 0, 30'h0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 30'h0, 0);
            n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 30'h0 || bus.inst_valid !== 1'b0)
                begin n_fail++; $display("FAIL stall_hold k=%0d got req=%0b addr=%h v=%0b exp req=1 addr=0 v=0", k, bus.imem_req, bus.imem_addr, bus.inst_valid); end
        end
        drive(1, 0, 0, 30'h0, 0);
        drive(0, 0, 0, 30'h0, 0);
        n_chk++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 30'h0 || bus.imem_addr !== 30'h1)
            begin n_fail++; $display("FAIL stall_single_push got v=%0b pc=%h addr=%h exp v=1 pc=0 addr=1", bus.inst_valid, bus.inst_pc, bus.imem_addr); end
        $display("test_ack_stall done");
    endtask

    task automatic test_redirect();
        do_reset();
        for (int k = 0; k < 4; k++) drive(1, 0, 0, 30'h0, 0);
        n_chk++; if (m_q.size() != 3 || bus.inst_pc !== 30'h0) begin n_fail++; $display("FAIL redir_setup got pc=%h exp pc=0 with 3 entries", bus.inst_pc); end
        drive(1, 0, 1, 30'h100, 0);
        n_chk++; if (bus.inst_valid !== 1'b0 || bus.imem_addr !== 30'h100 || bus.imem_req !== 1'b1)
            begin n_fail++; $display("FAIL redir_flush got v=%0b addr=%h req=%0b exp v=0 addr=100 req=1", bus.inst_valid, bus.imem_addr, bus.imem_req); end
        drive(1, 1, 0, 30'h0, 0);
        n_chk++; if (bus.inst_pc !== 30'h100 || bus.inst !== pat(30'h100)) begin n_fail++; $display("FAIL redir_first got pc=%h inst=%h exp pc=100 inst=%h", bus.inst_pc, bus.inst, pat(30'h100)); end
        drive(1, 1, 0, 30'h0, 0);
        n_chk++; if (bus.inst_pc !== 30'h101) begin n_fail++; $display("FAIL redir_second got=%h exp=101", bus.inst_pc); end
        $display("test_redirect done");
    endtask

    task automatic test_halt();
        do_reset();
        drive(0, 0, 0, 30'h0, 0);
        drive(0, 0, 0, 30'h0, 1);
        n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 30'h0 || bus.halted !== 1'b0)
            begin n_fail++; $display("FAIL halt_pend got req=%0b addr=%h halted=%0b exp req=1 addr=0 halted=0", bus.imem_req, bus.imem_addr, bus.halted); end
        drive(0, 0, 0, 30'h0, 0);
        n_chk++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL halt_pend_hold got=%0b exp=1", bus.imem_req); end
        drive(1, 0, 0, 30'h0, 0);
        n_chk++; if (bus.halted !== 1'b1 || bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b1 || bus.inst_pc !== 30'h0)
            begin n_fail++; $display("FAIL halt_done got halted=%0b req=%0b v=%0b pc=%h exp halted=1 req=0 v=1 pc=0", bus.halted, bus.imem_req, bus.inst_valid, bus.inst_pc); end
        drive(1, 1, 0, 30'h0, 0);
        n_chk++; if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b0 || bus.halted !== 1'b1)
            begin n_fail++; $display("FAIL halt_drain got v=%0b req=%0b halted=%0b exp v=0 req=0 halted=1", bus.inst_valid, bus.imem_req, bus.halted); end
        drive(1, 0, 1, 30'h20, 0);
        n_chk++; if (bus.halted !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 30'h20)
            begin n_fail++; $display("FAIL halt_resume got halted=%0b req=%0b addr=%h exp halted=0 req=1 addr=20", bus.halted, bus.imem_req, bus.imem_addr); end
        drive(1, 0, 0, 30'h0, 0);
        n_chk++; if (bus.inst_pc !== 30'h20) begin n_fail++; $display("FAIL halt_resume_pc got=%h exp=20", bus.inst_pc); end
        $display("test_halt done");
    endtask

    task automatic test_wrap();
        logic [29:0] exp_pc [3];
        exp_pc[0] = 30'h3FFFFFFE;
        exp_pc[1] = 30'h3FFFFFFF;
        exp_pc[2] = 30'h0;
        do_reset();
        drive(0, 0, 1, 30'h3FFFFFFE, 0);
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 0, 30'h0, 0);
            n_chk++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== exp_pc[k]) begin n_fail++; $display("FAIL wrap_pc k=%0d got=%h exp=%h", k, bus.inst_pc, exp_pc[k]); end
        end
        $display("test_wrap done");
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int k = 0; k < 3; k++) drive(1, 0, 0, 30'h0, 0);
        bus.imem_ack = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_chk++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 30'h0 || bus.inst_valid !== 1'b0 || bus.inst !== 32'h0)
            begin n_fail++; $display("FAIL mid_reset got req=%0b addr=%h v=%0b inst=%h exp all zero", bus.imem_req, bus.imem_addr, bus.inst_valid, bus.inst); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        drive(1, 1, 0, 30'h0, 0);
        n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 30'h0) begin n_fail++; $display("FAIL mid_reset_restart got req=%0b addr=%h exp req=1 addr=0", bus.imem_req, bus.imem_addr); end
        $display("test_mid_reset done");
    endtask

    task automatic test_random();
        logic a, r, rd, h;
        logic [29:0] ra;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            a  = ($urandom_range(0, 9) < 7);
            r  = ($urandom_range(0, 9) < 6);
            rd = ($urandom_range(0, 99) < 3);
            h  = ($urandom_range(0, 99) < 5);
            ra = ($urandom_range(0, 1) == 1) ? (30'h3FFFFFFC + 30'($urandom_range(0, 3))) : 30'($urandom);
            drive(a, r, rd, ra, h);
            n_chk++; if (bus.imem_req !== m_req || bus.imem_addr !== m_pc || bus.halted !== m_halted)
                begin n_fail++; $display("FAIL rand_ctrl c%0d got req=%0b addr=%h halted=%0b exp req=%0b addr=%h halted=%0b", c, bus.imem_req, bus.imem_addr, bus.halted, m_req, m_pc, m_halted); end
            n_chk++; if (bus.inst_valid !== (m_q.size() != 0))
                begin n_fail++; $display("FAIL rand_valid c%0d got=%0b exp=%0b", c, bus.inst_valid, (m_q.size() != 0)); end
            if (m_q.size() != 0) begin
                n_chk++; if (bus.inst_pc !== m_q[0] || bus.inst !== pat(m_q[0]))
                    begin n_fail++; $display("FAIL rand_head c%0d got pc=%h inst=%h exp pc=%h inst=%h", c, bus.inst_pc, bus.inst, m_q[0], pat(m_q[0])); end
            end
        end
        $display("test_random done");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_full();
        test_ack_stall();
        test_redirect();
        test_halt();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Hard stop in case anything stalls
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
